spi_cmd_parser: RTL and testbench

//   Consumes the byte stream from the SPI slave receiver (one byte per rx_dataValid pulse) and decodes host commands.

---
 rtl/spi_cmd_parser_pkg.sv | 16 +
 rtl/sync_2ff.sv | 26 ++
 rtl/spi_cmd_parser.sv | 156 +++++++++++++++
 tb/tb_spi_cmd_parser.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_parser_pkg.sv
// Shared definitions for the memory-LCD command path: host opcodes and parser FSM states.
// The LCD scan engine imports the same opcodes so both sides agree on the protocol.
package spi_cmd_parser_pkg;

  localparam logic [7:0] CMD_WRITE_LINE = 8'h01;
  localparam logic [7:0] CMD_CLEAR      = 8'h02;
  localparam logic [7:0] CMD_REFRESH    = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LINE_ADDR = 2'd1,
    ST_DATA      = 2'd2,
    ST_DISCARD   = 2'd3
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous control bit.
// RESET_VAL lets inactive-high signals such as chip selects start deasserted.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], i_d};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) sync_q <= {2{RESET_VAL}};
    else         sync_q <= sync_d;
  end

  assign o_q = sync_q[1];

endmodule

// File: rtl/spi_cmd_parser.sv
// Decodes the SPI byte stream into frame-buffer writes and CLEAR/REFRESH requests.
// Every output is registered, one clock after the byte strobe that causes it.
module spi_cmd_parser
  import spi_cmd_parser_pkg::*;
#(
  parameter int LINES          = 240,
  parameter int BYTES_PER_LINE = 50,
  parameter int AW             = 14
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_dataValid,
  input  logic          i_spi_nss,
  output logic          o_fb_wr_en,
  output logic [AW-1:0] o_fb_wr_addr,
  output logic [7:0]    o_fb_wr_data,
  output logic          o_line_done,
  output logic [7:0]    o_line_addr,
  output logic          o_clear_req,
  output logic          o_refresh_req,
  output logic          o_err
);

  localparam int               COL_W    = $clog2(BYTES_PER_LINE);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(BYTES_PER_LINE - 1);

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [AW-1:0]    base_q, base_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             line_done_q, line_done_d;
  logic [7:0]       line_addr_q, line_addr_d;
  logic             clear_q, clear_d;
  logic             refresh_q, refresh_d;
  logic             err_q, err_d;
  logic             nss_s;
  logic             line_ok;
  logic             last_col;

  sync_2ff #(.RESET_VAL(1'b1)) u_nss_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_spi_nss),
    .o_q     (nss_s)
  );

  assign line_ok  = 32'(i_rx_data) < 32'(LINES);
  assign last_col = (col_q == LAST_COL);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // A byte arriving together with nss_s wins; the abort is seen the cycle after.
  always_comb begin
    state_d = state_q;
    if (i_rx_dataValid) begin
      case (state_q)
        ST_IDLE: begin
          if (i_rx_data == CMD_WRITE_LINE)
            state_d = ST_LINE_ADDR;
          else if (i_rx_data != CMD_CLEAR && i_rx_data != CMD_REFRESH)
            state_d = ST_DISCARD;
        end
        ST_LINE_ADDR: state_d = line_ok ? ST_DATA : ST_DISCARD;
        ST_DATA:      if (last_col) state_d = ST_IDLE;
        default:      state_d = state_q;
      endcase
    end else if (nss_s) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    col_d       = col_q;
    base_d      = base_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    line_done_d = 1'b0;
    line_addr_d = line_addr_q;
    clear_d     = 1'b0;
    refresh_d   = 1'b0;
    err_d       = 1'b0;
    if (i_rx_dataValid) begin
      case (state_q)
        ST_IDLE: begin
          if (i_rx_data == CMD_CLEAR)        clear_d   = 1'b1;
          else if (i_rx_data == CMD_REFRESH) refresh_d = 1'b1;
          else if (i_rx_data != CMD_WRITE_LINE) err_d  = 1'b1;
        end
        ST_LINE_ADDR: begin
          if (line_ok) begin
            line_addr_d = i_rx_data;
            col_d       = '0;
            // The only multiply; the data path below just adds the column.
            base_d      = AW'(32'(i_rx_data) * 32'(BYTES_PER_LINE));
          end else begin
            err_d = 1'b1;
          end
        end
        ST_DATA: begin
          wr_en_d     = 1'b1;
          wr_addr_d   = base_q + AW'(col_q);
          wr_data_d   = i_rx_data;
          line_done_d = last_col;
          col_d       = last_col ? '0 : col_q + 1'b1;
        end
        default: ;
      endcase
    end else if (nss_s && (state_q == ST_LINE_ADDR || state_q == ST_DATA)) begin
      err_d = 1'b1;
      col_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      col_q       <= '0;
      base_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      line_done_q <= 1'b0;
      line_addr_q <= '0;
      clear_q     <= 1'b0;
      refresh_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      col_q       <= col_d;
      base_q      <= base_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      line_done_q <= line_done_d;
      line_addr_q <= line_addr_d;
      clear_q     <= clear_d;
      refresh_q   <= refresh_d;
      err_q       <= err_d;
    end
  end

  assign o_fb_wr_en    = wr_en_q;
  assign o_fb_wr_addr  = wr_addr_q;
  assign o_fb_wr_data  = wr_data_q;
  assign o_line_done   = line_done_q;
  assign o_line_addr   = line_addr_q;
  assign o_clear_req   = clear_q;
  assign o_refresh_req = refresh_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Transaction-level bench for spi_cmd_parser: each host command carries its own expected outputs.
module tb_spi_cmd_parser;

  localparam int LINES = 240;
  localparam int BPL   = 50;
  localparam int AW    = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_vld = 1'b0;
  logic          nss = 1'b1;
  logic          fb_wr_en;
  logic [AW-1:0] fb_wr_addr;
  logic [7:0]    fb_wr_data;
  logic          line_done;
  logic [7:0]    line_addr;
  logic          clear_req;
  logic          refresh_req;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_line = 0;
  int gap_max = 0;

  spi_cmd_parser #(.LINES(LINES), .BYTES_PER_LINE(BPL), .AW(AW)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_rx_data      (rx_data),
    .i_rx_dataValid (rx_vld),
    .i_spi_nss      (nss),
    .o_fb_wr_en     (fb_wr_en),
    .o_fb_wr_addr   (fb_wr_addr),
    .o_fb_wr_data   (fb_wr_data),
    .o_line_done    (line_done),
    .o_line_addr    (line_addr),
    .o_clear_req    (clear_req),
    .o_refresh_req  (refresh_req),
    .o_err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input bit wr, input int addr, input int data, input bit done,
                               input bit clr, input bit rf, input bit er);
    chk("wr_en", 32'(fb_wr_en), 32'(wr));
    if (wr) begin
      chk("wr_addr", 32'(fb_wr_addr), addr);
      chk("wr_data", 32'(fb_wr_data), data);
    end
    chk("line_done", 32'(line_done), 32'(done));
    chk("clear_req", 32'(clear_req), 32'(clr));
    chk("refresh_req", 32'(refresh_req), 32'(rf));
    chk("err", 32'(err), 32'(er));
    chk("line_addr", 32'(line_addr), exp_line);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      @(posedge clk);
      #1;
      check_outputs(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // One byte strobe; the registered response is sampled just after the capturing edge.
  task automatic send(input logic [7:0] b, input bit wr, input int addr, input int data,
                      input bit done, input bit clr, input bit rf, input bit er);
    @(negedge clk);
    rx_data = b;
    rx_vld  = 1'b1;
    @(posedge clk);
    #1;
    rx_vld = 1'b0;
    check_outputs(wr, addr, data, done, clr, rf, er);
    idle_cycles($urandom_range(0, gap_max));
  endtask

  task automatic write_line(input int line, input int nsend, input bit seq);
    logic [7:0] d;
    send(8'h01, 0, 0, 0, 0, 0, 0, 0);
    if (line < LINES) begin
      exp_line = line;
      send(8'(line), 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < nsend; i++) begin
        d = seq ? 8'(i) : 8'($urandom);
        send(d, 1, line * BPL + i, int'(d), i == BPL - 1, 0, 0, 0);
      end
    end else begin
      send(8'(line), 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < nsend; i++) send(8'($urandom), 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // Raise chip select long enough to pass the synchronizer, count error pulses, then lower it.
  task automatic nss_frame_end(input bit exp_err);
    int errs;
    errs = 0;
    @(negedge clk);
    nss = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      errs += int'(err);
      chk("nss_wr_en", 32'(fb_wr_en), 0);
      chk("nss_line_done", 32'(line_done), 0);
    end
    chk("nss_err_pulses", errs, 32'(exp_err));
    @(negedge clk);
    nss = 1'b0;
    idle_cycles(4);
  endtask

  initial begin
    int r, v, n;
    #23;
    idle_cycles(0);
    @(posedge clk);
    #1;
    check_outputs(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    nss = 1'b0;
    idle_cycles(4);

    // Back-to-back strobes across a full line.
    gap_max = 0;
    write_line(5, BPL, 1);
    gap_max = 2;

    send(8'h02, 0, 0, 0, 0, 1, 0, 0);
    send(8'h03, 0, 0, 0, 0, 0, 1, 0);

    write_line(240, BPL, 0);
    nss_frame_end(0);
    write_line(0, BPL, 0);

    write_line(7, 20, 0);
    nss_frame_end(1);
    send(8'h02, 0, 0, 0, 0, 1, 0, 0);

    send(8'h7E, 0, 0, 0, 0, 0, 0, 1);
    send(8'h01, 0, 0, 0, 0, 0, 0, 0);
    send(8'h02, 0, 0, 0, 0, 0, 0, 0);
    nss_frame_end(0);

    // Asynchronous reset in the middle of a line.
    write_line(9, 10, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_wr_en", 32'(fb_wr_en), 0);
    chk("rst_wr_addr", 32'(fb_wr_addr), 0);
    chk("rst_wr_data", 32'(fb_wr_data), 0);
    chk("rst_line_addr", 32'(line_addr), 0);
    chk("rst_line_done", 32'(line_done), 0);
    chk("rst_err", 32'(err), 0);
    exp_line = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(4);
    write_line(0, BPL, 0);

    for (int t = 0; t < 40; t++) begin
      gap_max = $urandom_range(0, 2);
      r = $urandom_range(0, 10);
      if (r <= 4) begin
        write_line($urandom_range(0, LINES - 1), BPL, 0);
      end else if (r == 5) begin
        send(8'h02, 0, 0, 0, 0, 1, 0, 0);
      end else if (r == 6) begin
        send(8'h03, 0, 0, 0, 0, 0, 1, 0);
      end else if (r == 7) begin
        v = $urandom_range(3, 255);
        if (v == 3) v = 0;
        send(8'(v), 0, 0, 0, 0, 0, 0, 1);
        n = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) send(8'($urandom), 0, 0, 0, 0, 0, 0, 0);
        nss_frame_end(0);
      end else if (r == 8) begin
        write_line($urandom_range(0, LINES - 1), $urandom_range(0, BPL - 1), 0);
        nss_frame_end(1);
      end else if (r == 9) begin
        write_line($urandom_range(LINES, 255), $urandom_range(0, 8), 0);
        nss_frame_end(0);
      end else begin
        nss_frame_end(0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
